// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IMEM_LOAD,
    IMEM_RUN,
    IMEM_HALT
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_if.sv
// Fetch port plus host load stream and status, shared by core/host (master) and instr_mem (slave).
interface instr_mem_if #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] InstrAddr;
  logic [31:0]       InstrMem;
  logic              LoadValid;
  logic [31:0]       LoadData;
  logic              LoadLast;
  logic              LoadReady;
  logic              Reload;
  logic              CoreRun;
  logic [CNT_W-1:0]  ProgSize;
  logic              Halted;
  logic              FetchErr;

  modport master (
    output InstrAddr, LoadValid, LoadData, LoadLast, Reload,
    input  InstrMem, LoadReady, CoreRun, ProgSize, Halted, FetchErr
  );

  modport slave (
    input  InstrAddr, LoadValid, LoadData, LoadLast, Reload,
    output InstrMem, LoadReady, CoreRun, ProgSize, Halted, FetchErr
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x 32 synchronous RAM: one write port, one registered read port.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory: host loads a program over a valid/ready stream, then
// serves one-cycle registered fetches to the core and flags end-of-program.
module instr_mem
  import imem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic Clock,
  input  logic nReset,
  instr_mem_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_t       state;
  logic [AW-1:0]     wptr;
  logic [CNT_W-1:0]  prog_size;
  logic              core_run;
  logic              halted;
  logic              fetch_err;
  logic              load_ready;
  logic              hit;
  logic [31:0]       rd_data;

  logic [ADDR_W-3:0] idx;
  logic [ADDR_W-3:0] psize_ext;
  logic              aligned;
  logic              wr_en;
  logic              last_hs;
  logic              hit_next;

  assign idx       = bus.InstrAddr[ADDR_W-1:2];
  assign psize_ext = (ADDR_W-2)'(prog_size);
  assign aligned   = (bus.InstrAddr[1:0] == 2'b00);
  assign wr_en     = bus.LoadValid & load_ready;
  assign last_hs   = wr_en & (bus.LoadLast | (wptr == AW'(DEPTH - 1)));
  assign hit_next  = (state == IMEM_RUN) && !bus.Reload && aligned && (idx < psize_ext);

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (Clock),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (bus.LoadData),
    .raddr (idx[AW-1:0]),
    .rdata (rd_data)
  );

  // RAM output is already registered; the registered hit flag gates it so
  // every non-hit cycle (LOAD, HALT, misaligned, out of range) reads as NOP.
  assign bus.InstrMem  = hit ? rd_data : NOP_INSTR;
  assign bus.LoadReady = load_ready;
  assign bus.CoreRun   = core_run;
  assign bus.ProgSize  = prog_size;
  assign bus.Halted    = halted;
  assign bus.FetchErr  = fetch_err;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IMEM_LOAD;
      wptr       <= '0;
      prog_size  <= '0;
      core_run   <= 1'b0;
      halted     <= 1'b0;
      fetch_err  <= 1'b0;
      load_ready <= 1'b0;
      hit        <= 1'b0;
    end else begin
      hit <= hit_next;
      unique case (state)
        IMEM_LOAD: begin
          load_ready <= 1'b1;
          if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (last_hs) begin
              prog_size  <= CNT_W'(wptr) + CNT_W'(1);
              state      <= IMEM_RUN;
              core_run   <= 1'b1;
              load_ready <= 1'b0;
            end
          end
        end
        IMEM_RUN, IMEM_HALT: begin
          if (bus.Reload) begin
            state      <= IMEM_LOAD;
            wptr       <= '0;
            prog_size  <= '0;
            core_run   <= 1'b0;
            halted     <= 1'b0;
            fetch_err  <= 1'b0;
            load_ready <= 1'b1;
          end else if (state == IMEM_RUN) begin
            if (!aligned) begin
              fetch_err <= 1'b1;
            end else if (idx == psize_ext) begin
              halted <= 1'b1;
              state  <= IMEM_HALT;
            end
          end
        end
        default: state <= IMEM_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios plus random
// load/fetch sessions checked against a transaction-level model.
module tb_instr_mem;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: program image and run status as plain variables.
  logic [31:0] mm [DEPTH];
  int  wp;
  int  psize;
  bit  running;
  bit  halted;
  bit  ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.LoadValid = 1'b0;
    bus.LoadLast  = 1'b0;
    bus.Reload    = 1'b0;
  endtask

  task automatic model_fetch(input logic [15:0] a, output logic [31:0] exp);
    int idx;
    idx = int'(a >> 2);
    exp = 32'h0;
    if (running && !halted) begin
      if (a[1:0] != 2'b00) ferr = 1'b1;
      else if (idx < psize) exp = mm[idx];
      else if (idx == psize) halted = 1'b1;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_run"},   32'(bus.CoreRun),  32'(running));
    check({tag, "_halt"},  32'(bus.Halted),   32'(halted));
    check({tag, "_ferr"},  32'(bus.FetchErr), 32'(ferr));
    check({tag, "_psize"}, 32'(bus.ProgSize), 32'(psize));
  endtask

  task automatic apply_reset();
    idle_bus();
    rst_n = 1'b0;
    #1;
    wp = 0; psize = 0; running = 0; halted = 0; ferr = 0;
    check_status("rst");
    check("rst_ready", 32'(bus.LoadReady), 32'h0);
    check("rst_instr", bus.InstrMem, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_rel_ready", 32'(bus.LoadReady), 32'h1);
  endtask

  task automatic push_word(input logic [31:0] data, input bit last);
    bit exp_ready;
    logic [31:0] exp;
    exp_ready = !running;
    check("pre_ready", 32'(bus.LoadReady), 32'(exp_ready));
    bus.LoadValid = 1'b1;
    bus.LoadData  = data;
    bus.LoadLast  = last;
    step();
    bus.LoadValid = 1'b0;
    bus.LoadLast  = 1'b0;
    exp = 32'h0;
    if (exp_ready) begin
      mm[wp] = data;
      if (last || wp == DEPTH - 1) begin
        psize   = wp + 1;
        running = 1'b1;
      end else begin
        wp++;
      end
    end else begin
      model_fetch(bus.InstrAddr, exp);
    end
    check("push_instr", bus.InstrMem, exp);
    check("post_ready", 32'(bus.LoadReady), 32'(!running));
    check_status("push");
  endtask

  task automatic fetch(input logic [15:0] a);
    logic [31:0] exp;
    bus.InstrAddr = a;
    step();
    model_fetch(a, exp);
    check("fetch_instr", bus.InstrMem, exp);
    check_status("fetch");
  endtask

  task automatic reload(input bit with_valid, input logic [31:0] data);
    bus.Reload    = 1'b1;
    bus.LoadValid = with_valid;
    bus.LoadData  = data;
    step();
    idle_bus();
    if (running) begin
      running = 0; halted = 0; ferr = 0; psize = 0; wp = 0;
    end
    check_status("reload");
    check("reload_instr", bus.InstrMem, 32'h0);
    check("reload_ready", 32'(bus.LoadReady), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prog [6];
    prog = '{32'h3C011234, 32'h34215678, 32'h3C025555,
             32'h34427777, 32'h00411820, 32'h00000000};
    idle_bus();
    bus.InstrAddr = '0;
    bus.LoadData  = '0;
    apply_reset();

    // LoadLast without LoadValid does nothing.
    bus.LoadLast = 1'b1;
    step();
    bus.LoadLast = 1'b0;
    check_status("lastonly");
    check("lastonly_ready", 32'(bus.LoadReady), 32'h1);

    // Six-word program, then fetches, misalignment, out-of-range, halt.
    foreach (prog[i]) push_word(prog[i], i == 5);
    fetch(16'h0000);
    fetch(16'h0010);
    fetch(16'h0002);
    fetch(16'h0040);
    fetch(16'h0014);
    fetch(16'h0018);
    fetch(16'h0004);

    // Reload with a concurrent word, then a full-depth load without LoadLast.
    reload(1'b1, 32'hDEADBEEF);
    for (int i = 0; i < DEPTH; i++) push_word(32'hA000_0000 + 32'(i), 1'b0);
    bus.InstrAddr = 16'h0000;
    push_word(32'hBAD0_0009, 1'b1);
    for (int i = 1; i <= DEPTH; i++) fetch(16'(i * 4));

    // Reset mid-load discards the partial program.
    reload(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) push_word(32'hC000_0000 + 32'(i), 1'b0);
    apply_reset();
    push_word(32'h1111_2222, 1'b0);
    push_word(32'h3333_4444, 1'b1);
    fetch(16'h0000);
    fetch(16'h0004);
    fetch(16'h0008);

    // Random sessions.
    for (int it = 0; it < 25; it++) begin
      int n;
      if (it % 6 == 5) apply_reset();
      else if (running) reload(1'($urandom_range(0, 1)), $urandom);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        bit last;
        if (i == n - 1) last = (n == DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1;
        else last = 1'b0;
        push_word($urandom, last);
      end
      for (int k = 0; k < 12; k++) begin
        logic [15:0] a;
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
          0:       a = 16'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
          1:       a = 16'(psize * 4);
          2:       a = 16'($urandom_range(psize + 1, 16000) * 4);
          default: a = 16'($urandom_range(0, psize + 1) * 4);
        endcase
        fetch(a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
- Synthesizable instruction memory that answers the PROCESSOR fetch port: InstrAddr in, InstrMem out.
- It is the fetch responder that replaces the behavioural program store.
- Before execution, a host loads the program through a valid/ready word stream; the block holds the core in reset until loading completes.
- Once running, it serves registered fetches, returns NOP outside the program, and flags end-of-program.

Parameters:
DEPTH, 256, number of 32-bit instruction words; must satisfy DEPTH <= 2**(ADDR_W-2)
ADDR_W, 16, width of InstrAddr (byte address)
CNT_W, $clog2(DEPTH)+1, width of ProgSize (derived; do not override)

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
InstrAddr  input  ADDR_W  byte fetch address from core
InstrMem  output  32  fetched instruction, registered
LoadValid  input  1  host word valid
LoadData  input  32  host instruction word
LoadLast  input  1  qualifies LoadValid; marks final word
LoadReady  output  1  block accepts a word this cycle
Reload  input  1  single-cycle request to return to LOAD
CoreRun  output  1  drives core nReset; high only while running or halted
ProgSize  output  CNT_W  number of words loaded
Halted  output  1  sticky; fetch reached one word past the program end
FetchErr  output  1  sticky; a misaligned fetch occurred while running

Behaviour:
- Reset (async, nReset low): state=LOAD, wptr=0, ProgSize=0, InstrMem=32'h0, CoreRun=0, Halted=0, FetchErr=0, LoadReady=0. Memory contents are not cleared.
- States: LOAD -> RUN -> HALT. Reload returns RUN or HALT to LOAD.
- LOAD:
  - LoadReady=1 from the first cycle after reset deasserts.
  - A handshake (LoadValid & LoadReady) writes mem[wptr] <= LoadData, then wptr++.
  - A handshake with LoadLast=1 sets ProgSize <= wptr+1 and moves to RUN next cycle.
  - A handshake at wptr==DEPTH-1 is treated as last regardless of LoadLast (forced RUN, ProgSize=DEPTH).
  - LoadReady is 0 in every state except LOAD.
  - InstrMem is held at 0 in LOAD.
- RUN:
  - CoreRun is registered and goes high on the first RUN cycle.
  - idx = InstrAddr[ADDR_W-1:2]. Each rising edge:
    - InstrMem <= mem[idx] if InstrAddr[1:0]==0 and idx < ProgSize.
    - Otherwise InstrMem <= 0 (NOP).
  - Latency is exactly 1 cycle; no back-pressure.
  - Misaligned address (InstrAddr[1:0]!=0): output 0 and set FetchErr (sticky until reset or Reload).
  - idx == ProgSize with aligned address: InstrMem <= 0, Halted <= 1, state -> HALT.
  - idx > ProgSize: output 0, no halt.
- HALT:
  - InstrMem is held at 0 and CoreRun stays 1, so the core state remains inspectable.
  - Halted stays 1. InstrAddr is ignored.
- Reload:
  - In RUN or HALT, on the next edge: state=LOAD, wptr=0, ProgSize=0, CoreRun=0, Halted=0, FetchErr=0, InstrMem=0.
  - Ignored in LOAD.
  - A LoadValid in the same cycle as Reload is not accepted.
- Reset mid-load discards the partial program. Reloading overwrites memory from index 0.
- LoadLast without LoadValid has no effect.

Decomposition:
- Package imem_pkg holds:
  - imem_state_t enum {IMEM_LOAD, IMEM_RUN, IMEM_HALT}
  - NOP_INSTR = 32'h0000_0000
- Sub-module imem_array: single-port-write / single-port-read synchronous RAM, DEPTH x 32, registered read.
- The FSM, pointers and flags stay in instr_mem.

Test Plan:
1. Load 6 words {3C011234, 34215678, 3C025555, 34427777, 00411820, 00000000}, last on the 6th -> ProgSize=6; CoreRun rises the cycle after the 6th handshake; LoadReady=0 afterwards.
2. After scenario 1, InstrAddr=0x0000 then 0x0010 -> InstrMem=3C011234 one cycle later, then 00411820; InstrAddr=0x0018 -> InstrMem=0, Halted=1, state HALT; a later InstrAddr=0x0004 still gives 0.
3. InstrAddr=0x0002 in RUN -> InstrMem=0, FetchErr=1 and stays 1; InstrAddr=0x0040 with ProgSize=6 -> InstrMem=0, Halted stays 0.
4. DEPTH=8: stream 8 words with LoadLast=0 -> forced RUN, ProgSize=8, LoadReady=0; a 9th LoadValid is not accepted.
5. Pull nReset low after 3 handshakes -> immediately ProgSize=0, CoreRun=0, LoadReady=0; after release, reload 2 words -> ProgSize=2, fetch 0x0 returns the new word 0.
6. In HALT, pulse Reload together with LoadValid -> LOAD next cycle, Halted=0, CoreRun=0, that word not written; the next handshake writes index 0.
